// File: rtl/apb_slave_mem_if.sv
// rtl/apb_slave_mem_if.sv - APB3 bus signal bundle between a requester and apb_slave_mem
//
// Purpose:
//   Groups the APB3 request and response signals so that the requester and
//   the memory connect through a single port.
//
// Signals:
//   PADDR    32  byte address (requester -> memory)
//   PWDATA   32  write data (requester -> memory)
//   PWRITE    1  1 = write, 0 = read (requester -> memory)
//   PSELx     1  slave select (requester -> memory)
//   PENABLE   1  access-phase strobe (requester -> memory)
//   PREADY    1  transfer complete (memory -> requester)
//   PRDATA   32  read data (memory -> requester)
//
// Modports:
//   master : drives the request, observes the response
//   slave  : observes the request, drives the response

interface apb_slave_mem_if;

  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSELx;
  logic        PENABLE;
  logic        PREADY;
  logic [31:0] PRDATA;

  modport master (
    output PADDR,
    output PWDATA,
    output PWRITE,
    output PSELx,
    output PENABLE,
    input  PREADY,
    input  PRDATA
  );

  modport slave (
    input  PADDR,
    input  PWDATA,
    input  PWRITE,
    input  PSELx,
    input  PENABLE,
    output PREADY,
    output PRDATA
  );

endinterface

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB3 completer memory, DEPTH x 32b, programmable wait states
//
// Purpose:
//   Word-addressed register file behind an APB3 completer. Each transfer is
//   one SETUP cycle followed by WAIT_STATES+1 ACCESS cycles. Address, write
//   data and direction are captured at SETUP; whatever the bus does during
//   ACCESS is ignored. Out-of-range writes are dropped and out-of-range reads
//   return OOR_DATA; there is no error response.
//
// Parameters:
//   DEPTH        number of 32-bit words (power of 2, >= 2)
//   WAIT_STATES  ACCESS cycles with PREADY low before PREADY rises (0..15)
//   OOR_DATA     read data returned for an out-of-range address
//
// Ports:
//   clk     clock, all logic on the rising edge
//   RESETn  synchronous active-low reset; clears FSM, outputs and memory
//   bus     apb_slave_mem_if slave modport (PADDR, PWDATA, PWRITE, PSELx,
//           PENABLE in; registered PREADY, PRDATA out)

module apb_slave_mem #(
  parameter int          DEPTH       = 16,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] OOR_DATA    = 32'hDEAD_BEEF
) (
  input  logic            clk,
  input  logic            RESETn,
  apb_slave_mem_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);
  localparam bit         NO_WAIT = (WAIT_STATES == 0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [3:0]    cnt;
  logic [3:0]    cnt_nxt;

  // Request captured at SETUP.
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          write_q;

  logic [31:0]   mem [DEPTH];

  logic          pready_q;
  logic [31:0]   prdata_q;

  logic          setup;
  logic          complete;
  logic          enter_ready;
  logic          rd_is_write;
  logic [31:0]   rd_addr;
  logic [AW-1:0] rd_idx;
  logic          rd_oor;
  logic [AW-1:0] wr_idx;
  logic          wr_oor;

  // Only word addresses matter; the byte-lane bits are deliberately dropped.
  logic unused_byte_lane;
  assign unused_byte_lane = ^bus.PADDR[1:0];

  assign setup    = (state == ST_IDLE) && bus.PSELx && !bus.PENABLE;
  assign complete = (state == ST_READY) && bus.PSELx && bus.PENABLE;

  // With no wait states READY is entered on the SETUP edge itself, when the
  // capture registers are still being loaded, so read data has to be fetched
  // using the live bus request on that edge and the captured one otherwise.
  assign rd_addr     = setup ? bus.PADDR  : addr_q;
  assign rd_is_write = setup ? bus.PWRITE : write_q;
  assign rd_idx      = rd_addr[2 +: AW];
  assign rd_oor      = |rd_addr[31:2+AW];

  assign wr_idx      = addr_q[2 +: AW];
  assign wr_oor      = |addr_q[31:2+AW];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        // PENABLE without a prior SETUP falls through here and is ignored.
        if (setup) begin
          cnt_nxt   = WS_INIT;
          state_nxt = NO_WAIT ? ST_READY : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!bus.PSELx) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
          // cnt <= 1 rather than == 1 so a corrupted count cannot strand us.
          if (cnt <= 4'd1) begin
            state_nxt = ST_READY;
          end
        end
      end
      ST_READY: begin
        // Leave on completion or abort; PSELx with PENABLE low just holds.
        if (!bus.PSELx || bus.PENABLE) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign enter_ready = (state != ST_READY) && (state_nxt == ST_READY);

  always_ff @(posedge clk) begin
    if (!RESETn) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      pready_q <= 1'b0;
      prdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pready_q <= (state_nxt == ST_READY);

      if (setup) begin
        addr_q  <= bus.PADDR;
        wdata_q <= bus.PWDATA;
        write_q <= bus.PWRITE;
      end

      // PRDATA only moves when a read reaches READY; writes and aborts leave it.
      if (enter_ready && !rd_is_write) begin
        prdata_q <= rd_oor ? OOR_DATA : mem[rd_idx];
      end

      if (complete && write_q && !wr_oor) begin
        mem[wr_idx] <= wdata_q;
      end
    end
  end

  assign bus.PREADY = pready_q;
  assign bus.PRDATA = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - self-checking bench for apb_slave_mem with 0, 3 and 2 wait states

module tb_apb_slave_mem;

  localparam logic [31:0] OOR = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic resetn;

  logic [31:0] paddr   [3];
  logic [31:0] pwdata  [3];
  logic        pwrite  [3];
  logic        psel    [3];
  logic        penable [3];
  logic        pready  [3];
  logic [31:0] prdata  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int GWS = (g == 0) ? 0 : (g == 1) ? 3 : 2;
    apb_slave_mem_if u_if ();
    assign u_if.PADDR   = paddr[g];
    assign u_if.PWDATA  = pwdata[g];
    assign u_if.PWRITE  = pwrite[g];
    assign u_if.PSELx   = psel[g];
    assign u_if.PENABLE = penable[g];
    assign pready[g]    = u_if.PREADY;
    assign prdata[g]    = u_if.PRDATA;
    apb_slave_mem #(.DEPTH(16), .WAIT_STATES(GWS), .OOR_DATA(OOR)) u_dut (
      .clk    (clk),
      .RESETn (resetn),
      .bus    (u_if)
    );
  end

  int n_pass = 0;
  int n_total = 0;

  // Reference: each DUT is just 16 words; a transfer either lands or it doesn't.
  logic [31:0] model [3][16];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 3 : 2;
  endfunction

  function automatic logic [31:0] model_rd(input int d, input logic [31:0] a);
    if (a[31:6] != 26'd0) return OOR;
    return model[d][a[5:2]];
  endfunction

  task automatic model_wr(input int d, input logic [31:0] a, input logic [31:0] wd);
    if (a[31:6] == 26'd0) model[d][a[5:2]] = wd;
  endtask

  task automatic model_clear();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 16; i++) model[d][i] = 32'h0;
  endtask

  task automatic idle(input int d, input int n);
    psel[d] = 1'b0;
    penable[d] = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One full transfer starting in the current cycle; ends right after the
  // completion edge with the bus still in ACCESS so a following call is
  // back-to-back. Bus request is scrambled during ACCESS to prove latching.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd);
    int waits;
    logic [31:0] prev;
    prev = prdata[d];
    psel[d] = 1'b1;
    penable[d] = 1'b0;
    pwrite[d] = wr;
    paddr[d] = a;
    pwdata[d] = wd;
    @(posedge clk);
    #1;
    penable[d] = 1'b1;
    paddr[d] = $urandom;
    pwdata[d] = $urandom;
    pwrite[d] = ~wr;
    waits = 0;
    while (pready[d] !== 1'b1 && waits <= 40) begin
      @(posedge clk);
      #1;
      waits++;
    end
    chk("latency", 32'(waits), 32'(ws_of(d)));
    rd = prdata[d];
    if (wr) chk("prdata_hold_on_write", prdata[d], prev);
    @(posedge clk);
    #1;
    chk("pready_drop", {31'd0, pready[d]}, 32'd0);
    if (wr) model_wr(d, a, wd);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] held;
    bit          wr;

    tbl[0]  = '{1'b1, 32'h0000_0004, 32'hA5A5_0001, 32'h0};
    tbl[1]  = '{1'b0, 32'h0000_0004, 32'h0,         32'hA5A5_0001};
    tbl[2]  = '{1'b1, 32'h0000_0000, 32'h0000_1111, 32'h0};
    tbl[3]  = '{1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 32'h0};
    tbl[4]  = '{1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF};
    tbl[5]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_1111};
    tbl[6]  = '{1'b0, 32'h0000_003C, 32'h0,         32'h0000_0000};
    tbl[7]  = '{1'b1, 32'h0000_003F, 32'h7777_0003, 32'h0};
    tbl[8]  = '{1'b0, 32'h0000_003C, 32'h0,         32'h7777_0003};
    tbl[9]  = '{1'b0, 32'h8000_0000, 32'h0,         32'hDEAD_BEEF};
    tbl[10] = '{1'b1, 32'h0000_0044, 32'h0000_0001, 32'h0};
    tbl[11] = '{1'b0, 32'h0000_0004, 32'h0,         32'hA5A5_0001};

    for (int d = 0; d < 3; d++) begin
      paddr[d] = 32'h0;
      pwdata[d] = 32'h0;
      pwrite[d] = 1'b0;
      psel[d] = 1'b0;
      penable[d] = 1'b0;
    end
    model_clear();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_pready", {31'd0, pready[d]}, 32'd0);
      chk("reset_prdata", prdata[d], 32'h0);
    end
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Table: zero-wait basics, range boundaries and out-of-range aliasing.
    for (int i = 0; i < 12; i++) begin
      xfer(0, tbl[i].wr, tbl[i].addr, tbl[i].data, rd);
      if (!tbl[i].wr) chk("table_read", rd, tbl[i].exp);
    end
    idle(0, 1);

    // Three wait states.
    xfer(1, 1'b1, 32'h8, 32'h1234_5678, rd);
    idle(1, 1);
    xfer(1, 1'b0, 32'h8, 32'h0, rd);
    chk("ws3_read", rd, 32'h1234_5678);
    idle(1, 1);

    // Back-to-back fill then readback, no idle cycles.
    for (int i = 0; i < 16; i++) xfer(0, 1'b1, 32'(i * 4), 32'(i), rd);
    for (int i = 0; i < 16; i++) begin
      xfer(0, 1'b0, 32'(i * 4), 32'h0, rd);
      chk("b2b_read", rd, 32'(i));
    end
    idle(0, 1);

    // PENABLE without SETUP is ignored.
    psel[1] = 1'b1;
    penable[1] = 1'b1;
    pwrite[1] = 1'b0;
    paddr[1] = 32'h8;
    repeat (5) @(posedge clk);
    #1;
    chk("no_setup_pready", {31'd0, pready[1]}, 32'd0);
    idle(1, 1);

    // Abort in the first WAIT cycle.
    xfer(2, 1'b1, 32'hC, 32'h0000_00C0, rd);
    xfer(2, 1'b0, 32'hC, 32'h0, rd);
    held = prdata[2];
    psel[2] = 1'b1;
    penable[2] = 1'b0;
    pwrite[2] = 1'b1;
    paddr[2] = 32'hC;
    pwdata[2] = 32'hFFFF_0000;
    @(posedge clk);
    #1;
    penable[2] = 1'b1;
    psel[2] = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_wait_pready", {31'd0, pready[2]}, 32'd0);
    chk("abort_wait_prdata", prdata[2], held);
    idle(2, 2);
    xfer(2, 1'b0, 32'hC, 32'h0, rd);
    chk("abort_wait_read", rd, 32'h0000_00C0);
    idle(2, 1);

    // Abort while READY.
    psel[0] = 1'b1;
    penable[0] = 1'b0;
    pwrite[0] = 1'b1;
    paddr[0] = 32'h10;
    pwdata[0] = 32'h0BAD_0BAD;
    @(posedge clk);
    #1;
    chk("ready_pready", {31'd0, pready[0]}, 32'd1);
    psel[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_ready_pready", {31'd0, pready[0]}, 32'd0);
    idle(0, 1);
    xfer(0, 1'b0, 32'h10, 32'h0, rd);
    chk("abort_ready_read", rd, model_rd(0, 32'h10));
    idle(0, 1);

    // Randomized traffic against the word-array model.
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 30; k++) begin
        wr = 1'($urandom_range(0, 1));
        a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
        if ($urandom_range(0, 7) == 0) a[31:6] = 26'($urandom_range(1, 32'h3FF_FFFF));
        wd = $urandom;
        xfer(d, wr, a, wd, rd);
        if (!wr) chk("rand_read", rd, model_rd(d, a));
        if ($urandom_range(0, 2) == 0) idle(d, $urandom_range(1, 3));
      end
      idle(d, 1);
    end

    // Reset in the ACCESS cycle of a write.
    xfer(0, 1'b1, 32'h4, 32'h1357_9BDF, rd);
    xfer(0, 1'b0, 32'h4, 32'h0, rd);
    psel[0] = 1'b1;
    penable[0] = 1'b0;
    pwrite[0] = 1'b1;
    paddr[0] = 32'h4;
    pwdata[0] = 32'h5555_AAAA;
    @(posedge clk);
    #1;
    penable[0] = 1'b1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("midreset_pready", {31'd0, pready[d]}, 32'd0);
      chk("midreset_prdata", prdata[d], 32'h0);
    end
    resetn = 1'b1;
    model_clear();
    idle(0, 1);
    for (int i = 0; i < 16; i++) begin
      xfer(0, 1'b0, 32'(i * 4), 32'h0, rd);
      chk("post_reset_read", rd, 32'h0);
    end
    idle(0, 1);
    xfer(1, 1'b0, 32'h8, 32'h0, rd);
    chk("post_reset_read_ws3", rd, 32'h0);
    idle(1, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
